// File: rtl/alu_regfile_pipe_if.sv
// rtl/alu_regfile_pipe_if.sv - load port, issue handshake and result bundle for alu_regfile_pipe
interface alu_regfile_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 16
);
  localparam int ADDR_W = $clog2(REG_COUNT);

  logic              writeEnable;
  logic [ADDR_W-1:0] writeReg;
  logic [WIDTH-1:0]  writeData;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        ALUControl;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic              destEnable;
  logic [ADDR_W-1:0] destReg;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  ALUResult;
  logic              Zero;
  logic              Carry;
  logic              Negative;
  logic              Overflow;
  logic              Illegal;

  modport master (
    output writeEnable, writeReg, writeData, in_valid, ALUControl, readReg1, readReg2,
           destEnable, destReg, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Carry, Negative, Overflow, Illegal
  );

  modport slave (
    input  writeEnable, writeReg, writeData, in_valid, ALUControl, readReg1, readReg2,
           destEnable, destReg, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Carry, Negative, Overflow, Illegal
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// rtl/alu_regfile_pipe.sv - register file with two-stage ALU pipeline, write-back and bypass
// Optional multiplier on opcode 1010 enabled by defining ALU_PIPE_MUL_EN.
module alu_regfile_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_regfile_pipe_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_COUNT);
  localparam int SH_W   = $clog2(WIDTH);

  logic [WIDTH-1:0]  regs [REG_COUNT];

  logic              s1_valid;
  logic [3:0]        s1_op;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  logic              s1_de;
  logic [ADDR_W-1:0] s1_dr;

  logic              out_valid_q;
  logic [WIDTH-1:0]  res_q;
  logic              z_q, c_q, n_q, v_q, i_q;

  logic              advance;
  logic              s1_fire;
  logic              wb_en;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c, alu_v, alu_i;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;

  assign advance      = !out_valid_q || bus.out_ready;
  assign s1_fire      = s1_valid && advance;
  assign bus.in_ready = !s1_valid || advance;
  assign wb_en        = s1_fire && s1_de && (s1_dr != '0);

  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = res_q;
  assign bus.Zero      = z_q;
  assign bus.Carry     = c_q;
  assign bus.Negative  = n_q;
  assign bus.Overflow  = v_q;
  assign bus.Illegal   = i_q;

  always_comb begin
    sum     = {1'b0, s1_a} + {1'b0, s1_b};
    diff    = {1'b0, s1_a} - {1'b0, s1_b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_i   = 1'b0;
    case (s1_op)
      4'b0000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      4'b0001: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      4'b0010: alu_res = s1_a & s1_b;
      4'b0011: alu_res = s1_a | s1_b;
      4'b0100: alu_res = s1_a ^ s1_b;
      4'b0101: alu_res = s1_a << s1_b[SH_W-1:0];
      4'b0110: alu_res = s1_a >> s1_b[SH_W-1:0];
      4'b0111: alu_res = WIDTH'($signed(s1_a) >>> s1_b[SH_W-1:0]);
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
`ifdef ALU_PIPE_MUL_EN
      4'b1010: alu_res = s1_a * s1_b;
`endif
      default: alu_i = 1'b1;
    endcase
  end

  // Operands that name the register being written back this edge take the fresh result.
  always_comb begin
    opa = (bus.readReg1 == '0) ? '0 : regs[bus.readReg1];
    opb = (bus.readReg2 == '0) ? '0 : regs[bus.readReg2];
    if (wb_en && (bus.readReg1 == s1_dr)) opa = alu_res;
    if (wb_en && (bus.readReg2 == s1_dr)) opb = alu_res;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      s1_valid    <= 1'b0;
      s1_op       <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_de       <= 1'b0;
      s1_dr       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      i_q         <= 1'b0;
    end else begin
      if (bus.writeEnable && (bus.writeReg != '0)) regs[bus.writeReg] <= bus.writeData;
      if (wb_en) regs[s1_dr] <= alu_res;

      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op <= bus.ALUControl;
          s1_a  <= opa;
          s1_b  <= opb;
          s1_de <= bus.destEnable;
          s1_dr <= bus.destReg;
        end
      end

      if (s1_fire) begin
        out_valid_q <= 1'b1;
        res_q       <= alu_res;
        z_q         <= (alu_res == '0);
        c_q         <= alu_c;
        n_q         <= alu_res[WIDTH-1];
        v_q         <= alu_v;
        i_q         <= alu_i;
      end else if (advance) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule
